// File: rtl/prefetch_byte_queue.sv
// Byte-granular circular queue between the prefetch stage and the decoder.
// Holds 1..16-byte fetch fragments, shows an 8-byte window, and carries sticky limit/page-fault markers.
module prefetch_byte_queue #(
    parameter int DEPTH_BYTES  = 32,
    parameter int WINDOW_BYTES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pr_reset,
    input  logic         prefetched_do,
    input  logic [127:0] prefetched_data,
    input  logic [4:0]   prefetched_length,
    input  logic         prefetchfifo_signal_limit_do,
    input  logic         prefetchfifo_signal_pf_do,
    input  logic         prefetched_accept_do,
    input  logic [3:0]   prefetched_accept_length,
    output logic [5:0]   prefetchfifo_used,
    output logic         prefetchfifo_ready,
    output logic [63:0]  fetch_data,
    output logic [3:0]   fetch_valid,
    output logic         fetch_limit,
    output logic         fetch_page_fault
);

    localparam int PW = $clog2(DEPTH_BYTES);
    localparam int UW = PW + 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [UW-1:0] used_q, used_d;
    logic          limit_q, limit_d;
    logic          pf_q, pf_d;

    logic [7:0]             mem [DEPTH_BYTES];
    logic [DEPTH_BYTES-1:0] we;
    logic [7:0]             wbyte [DEPTH_BYTES];

    logic [3:0]    valid_w;
    logic          enq_ok;
    logic          deq_ok;
    logic [UW:0]   space_w;

    assign valid_w = (used_q >= UW'(WINDOW_BYTES)) ? 4'(WINDOW_BYTES) : used_q[3:0];

    assign deq_ok = prefetched_accept_do
                 && (prefetched_accept_length != 4'd0)
                 && (prefetched_accept_length <= 4'(WINDOW_BYTES))
                 && (prefetched_accept_length <= valid_w);

    // Space counts bytes being retired this cycle, so a full queue can still take a fragment.
    assign space_w = (UW+1)'(DEPTH_BYTES) - (UW+1)'(used_q)
                   + (UW+1)'(deq_ok ? prefetched_accept_length : 4'd0);

    assign enq_ok = prefetched_do
                 && (prefetched_length != 5'd0)
                 && (prefetched_length <= 5'd16)
                 && ((UW+1)'(prefetched_length) <= space_w);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        used_d   = used_q;
        limit_d  = limit_q;
        pf_d     = pf_q;
        if (pr_reset) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            used_d   = '0;
            limit_d  = 1'b0;
            pf_d     = 1'b0;
        end else begin
            if (enq_ok) wr_ptr_d = wr_ptr_q + PW'(prefetched_length);
            if (deq_ok) rd_ptr_d = rd_ptr_q + PW'(prefetched_accept_length);
            used_d  = used_q
                    + UW'(enq_ok ? prefetched_length : 5'd0)
                    - UW'(deq_ok ? prefetched_accept_length : 4'd0);
            limit_d = limit_q | prefetchfifo_signal_limit_do;
            pf_d    = pf_q | prefetchfifo_signal_pf_do;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            used_q   <= '0;
            limit_q  <= 1'b0;
            pf_q     <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            used_q   <= used_d;
            limit_q  <= limit_d;
            pf_q     <= pf_d;
        end
    end

    // Each entry picks its byte by its distance from wr_ptr; only the first 'length' entries write.
    generate
        for (genvar gi = 0; gi < DEPTH_BYTES; gi++) begin : g_wr
            logic [PW-1:0] off;
            assign off       = PW'(gi) - wr_ptr_q;
            assign we[gi]    = enq_ok && !pr_reset && (UW'(off) < UW'(prefetched_length));
            assign wbyte[gi] = prefetched_data[8*off[3:0] +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH_BYTES; e++) begin
            if (we[e]) mem[e] <= wbyte[e];
        end
    end

    generate
        for (genvar gi = 0; gi < WINDOW_BYTES; gi++) begin : g_rd
            logic [PW-1:0] idx;
            assign idx = rd_ptr_q + PW'(gi);
            assign fetch_data[8*gi +: 8] = (4'(gi) < valid_w) ? mem[idx] : 8'h00;
        end
    endgenerate

    assign fetch_valid        = valid_w;
    assign prefetchfifo_used  = used_q[5:0];
    assign prefetchfifo_ready = ((UW+1)'(DEPTH_BYTES) - (UW+1)'(used_q)) >= (UW+1)'(16);
    assign fetch_limit        = limit_q && (used_q == '0);
    assign fetch_page_fault   = pf_q && (used_q == '0);

endmodule

// File: tb/tb_prefetch_byte_queue.sv
// Directed bench for prefetch_byte_queue: fill/drain, wrap, space rules, markers, reset and flush.
module tb_prefetch_byte_queue;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pr_reset;
    logic         prefetched_do;
    logic [127:0] prefetched_data;
    logic [4:0]   prefetched_length;
    logic         limit_do;
    logic         pf_do;
    logic         accept_do;
    logic [3:0]   accept_length;
    logic [5:0]   used;
    logic         ready;
    logic [63:0]  fetch_data;
    logic [3:0]   fetch_valid;
    logic         fetch_limit;
    logic         fetch_page_fault;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    prefetch_byte_queue #(.DEPTH_BYTES(32), .WINDOW_BYTES(8)) dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .pr_reset                     (pr_reset),
        .prefetched_do                (prefetched_do),
        .prefetched_data              (prefetched_data),
        .prefetched_length            (prefetched_length),
        .prefetchfifo_signal_limit_do (limit_do),
        .prefetchfifo_signal_pf_do    (pf_do),
        .prefetched_accept_do         (accept_do),
        .prefetched_accept_length     (accept_length),
        .prefetchfifo_used            (used),
        .prefetchfifo_ready           (ready),
        .fetch_data                   (fetch_data),
        .fetch_valid                  (fetch_valid),
        .fetch_limit                  (fetch_limit),
        .fetch_page_fault             (fetch_page_fault)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got=%0h exp=%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ramp(input logic [7:0] start);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = start + 8'(i);
        return v;
    endfunction

    task automatic idle_inputs();
        pr_reset          = 1'b0;
        prefetched_do     = 1'b0;
        prefetched_data   = '0;
        prefetched_length = '0;
        limit_do          = 1'b0;
        pf_do             = 1'b0;
        accept_do         = 1'b0;
        accept_length     = '0;
    endtask

    // One clock with the given inputs; returns #1 after the edge with inputs idle.
    task automatic cyc(input logic e, input logic [7:0] start, input logic [4:0] len,
                       input logic a, input logic [3:0] alen,
                       input logic lim, input logic pf, input logic flush);
        prefetched_do     = e;
        prefetched_data   = ramp(start);
        prefetched_length = len;
        accept_do         = a;
        accept_length     = alen;
        limit_do          = lim;
        pf_do             = pf;
        pr_reset          = flush;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_used", 64'(used), 64'd0);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_data", fetch_data, 64'd0);
        chk("rst_valid", 64'(fetch_valid), 64'd0);
        chk("rst_limit", 64'(fetch_limit), 64'd0);
        chk("rst_pf", 64'(fetch_page_fault), 64'd0);
        rst_n = 1'b1;

        // 16 bytes 0x00..0x0F
        cyc(1, 8'h00, 5'd16, 0, 0, 0, 0, 0);
        chk("enq16_used", 64'(used), 64'd16);
        chk("enq16_valid", 64'(fetch_valid), 64'd8);
        chk("enq16_data", fetch_data, 64'h0706050403020100);
        chk("enq16_ready", 64'(ready), 64'd1);

        cyc(0, 0, 0, 1, 4'd3, 0, 0, 0);
        chk("acc3_used", 64'(used), 64'd13);
        chk("acc3_data", fetch_data, 64'h0A09080706050403);
        cyc(0, 0, 0, 1, 4'd9, 0, 0, 0);
        chk("acc9_ign", 64'(used), 64'd13);

        // Fill to 32, wr_ptr wraps to 3
        cyc(1, 8'h10, 5'd16, 0, 0, 0, 0, 0);
        chk("fill29_used", 64'(used), 64'd29);
        chk("fill29_ready", 64'(ready), 64'd0);
        cyc(1, 8'h20, 5'd3, 0, 0, 0, 0, 0);
        chk("full_used", 64'(used), 64'd32);
        cyc(1, 8'h60, 5'd1, 0, 0, 0, 0, 0);
        chk("full_drop", 64'(used), 64'd32);

        // Drain rd_ptr 3 -> 28
        cyc(0, 0, 0, 1, 4'd8, 0, 0, 0);
        chk("d24_used", 64'(used), 64'd24);
        chk("d24_ready", 64'(ready), 64'd0);
        cyc(0, 0, 0, 1, 4'd8, 0, 0, 0);
        chk("d16_ready", 64'(ready), 64'd1);
        cyc(0, 0, 0, 1, 4'd8, 0, 0, 0);
        cyc(0, 0, 0, 1, 4'd1, 0, 0, 0);
        chk("d7_used", 64'(used), 64'd7);
        chk("d7_valid", 64'(fetch_valid), 64'd7);
        chk("d7_data", fetch_data, 64'h00222120_1F1E1D1C);
        cyc(0, 0, 0, 1, 4'd8, 0, 0, 0);
        chk("acc_gt_valid", 64'(used), 64'd7);
        cyc(1, 8'h23, 5'd1, 0, 0, 0, 0, 0);
        chk("wrap_data", fetch_data, 64'h23222120_1F1E1D1C);

        // used=20 space rules
        cyc(1, 8'h30, 5'd12, 0, 0, 0, 0, 0);
        chk("u20_used", 64'(used), 64'd20);
        cyc(1, 8'h40, 5'd16, 1, 4'd8, 0, 0, 0);
        chk("enq_deq_used", 64'(used), 64'd28);
        chk("enq_deq_data", fetch_data, 64'h37363534_33323130);
        cyc(0, 0, 0, 1, 4'd8, 0, 0, 0);
        chk("back20_used", 64'(used), 64'd20);
        chk("back20_data", fetch_data, 64'h43424140_3B3A3938);
        cyc(1, 8'h50, 5'd16, 0, 0, 0, 0, 0);
        chk("nospace_used", 64'(used), 64'd20);
        chk("nospace_data", fetch_data, 64'h43424140_3B3A3938);

        // Flush, then illegal lengths on an empty queue
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("flush_used", 64'(used), 64'd0);
        cyc(1, 8'h70, 5'd0, 0, 0, 0, 0, 0);
        chk("len0_used", 64'(used), 64'd0);
        cyc(1, 8'h70, 5'd17, 0, 0, 0, 0, 0);
        chk("len17_used", 64'(used), 64'd0);

        // Limit marker orders behind same-cycle bytes
        cyc(1, 8'h80, 5'd5, 0, 0, 1, 0, 0);
        chk("lim_hidden", 64'(fetch_limit), 64'd0);
        chk("lim_used5", 64'(used), 64'd5);
        cyc(0, 0, 0, 1, 4'd5, 0, 0, 0);
        chk("lim_used0", 64'(used), 64'd0);
        chk("lim_shown", 64'(fetch_limit), 64'd1);
        chk("lim_pf_off", 64'(fetch_page_fault), 64'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("lim_flushed", 64'(fetch_limit), 64'd0);

        // Page fault while empty: visible next cycle
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("pf_latency", 64'(fetch_page_fault), 64'd1);
        cyc(1, 8'h90, 5'd4, 0, 0, 0, 0, 0);
        chk("pf_hidden", 64'(fetch_page_fault), 64'd0);
        cyc(1, 8'h94, 5'd8, 0, 0, 0, 0, 0);
        chk("pre_rst_used", 64'(used), 64'd12);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_used", 64'(used), 64'd0);
        chk("arst_ready", 64'(ready), 64'd1);
        chk("arst_data", fetch_data, 64'd0);
        chk("arst_valid", 64'(fetch_valid), 64'd0);
        chk("arst_pf", 64'(fetch_page_fault), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cyc(1, 8'hA0, 5'd8, 0, 0, 0, 0, 0);
        chk("pre_fl_used", 64'(used), 64'd8);
        cyc(1, 8'hB0, 5'd4, 1, 4'd2, 1, 1, 1);
        chk("fl_pri_used", 64'(used), 64'd0);
        chk("fl_pri_lim", 64'(fetch_limit), 64'd0);
        chk("fl_pri_pf", 64'(fetch_page_fault), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prefetch_byte_queue.md
Name: prefetch_byte_queue

Overview:
- Byte-granular circular queue directly downstream of the prefetch address/limit stage.
- Captures 1..16-byte prefetched line fragments and presents an 8-byte little-endian window to the decoder.
- Retires bytes on the decoder's accept handshake.
- Carries sticky limit and page-fault markers. A marker surfaces only after every byte fetched ahead of it has been consumed.

Parameters:
- DEPTH_BYTES, 32, queue capacity in bytes; power of two, at least 32.
- WINDOW_BYTES, 8, bytes presented to the decoder per cycle; fixed at 8 in this revision.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- pr_reset  in  1  pipeline flush; clears all contents and markers
- prefetched_do  in  1  enqueue strobe from fetch path
- prefetched_data  in  128  fetched bytes; byte0 = [7:0]
- prefetched_length  in  5  valid bytes in prefetched_data, 1..16
- prefetchfifo_signal_limit_do  in  1  CS limit reached; set limit marker
- prefetchfifo_signal_pf_do  in  1  page fault on fetch; set pf marker
- prefetched_accept_do  in  1  decoder consumes bytes
- prefetched_accept_length  in  4  bytes consumed, 1..8
- prefetchfifo_used  out  6  bytes currently held, 0..32
- prefetchfifo_ready  out  1  free space is at least 16 bytes
- fetch_data  out  64  next 8 queued bytes; lanes at or beyond fetch_valid read zero
- fetch_valid  out  4  min(used, 8)
- fetch_limit  out  1  limit marker pending and queue empty
- fetch_page_fault  out  1  pf marker pending and queue empty

Behaviour:
- Storage:
  - DEPTH_BYTES x 8 register array.
  - 5-bit rd_ptr and wr_ptr, both wrapping mod DEPTH_BYTES.
  - 6-bit used counter.
- Reset (rst_n=0, asynchronous):
  - rd_ptr, wr_ptr and used go to 0; both markers clear.
  - Outputs: used=0, ready=1, fetch_data=0, fetch_valid=0, fetch_limit=0, fetch_page_fault=0.
  - Array contents are don't-care.
- pr_reset (synchronous, highest priority):
  - Same register result as reset.
  - All same-cycle enqueue, accept and marker inputs are ignored.
- Enqueue:
  - Legal when prefetched_do=1, 1 <= length <= 16, and length <= (DEPTH_BYTES - used + dequeued_this_cycle).
  - Byte i of prefetched_data is written to wr_ptr+i (mod depth); wr_ptr advances by length.
  - Length 0 or 17..31 is a no-op.
  - Insufficient space is a no-op; nothing is partially written.
- Dequeue:
  - Legal when prefetched_accept_do=1, 1 <= length <= 8, and length <= fetch_valid.
  - rd_ptr advances by length. Illegal accepts, including length 0, are ignored.
- Simultaneous enqueue and dequeue:
  - used' = used + enq_len - deq_len.
  - The dequeue frees space in the same cycle, so an enqueue into a full queue with a concurrent accept is accepted when it fits.
- Outputs:
  - fetch_data is combinational from the array at rd_ptr, including wrap across index DEPTH_BYTES-1 to 0.
  - Data enqueued in cycle N is visible in fetch_data/fetch_valid in cycle N+1. There is no same-cycle bypass.
- prefetchfifo_ready = (DEPTH_BYTES - used) >= 16, registered-state based. Upstream issues a 16-byte request only while ready=1.
- Markers:
  - limit_pending sets on prefetchfifo_signal_limit_do; pf_pending sets on prefetchfifo_signal_pf_do.
  - Both are sticky until pr_reset or reset.
  - fetch_limit = limit_pending && used==0; fetch_page_fault = pf_pending && used==0.
  - If both are pending, both outputs assert; the decoder prioritises.
  - A marker set in the same cycle as an enqueue orders after those bytes.
- Enqueue after a marker is set is still accepted. Upstream must not do this; the queue does not police it.
- Latency: marker input in cycle N with used==0 gives the fault output in cycle N+1.
- No state machine beyond the pointers; markers form a two-bit sticky state.

Test Plan:
- Reset release, then enqueue 16 bytes 0x00..0x0F -> next cycle used=16, fetch_valid=8, fetch_data=0x0706050403020100, ready=1.
- Accept length 3 -> next cycle used=13, fetch_data=0x0A09080706050403; then accept length 9 -> ignored, used stays 13.
- Fill to used=32 with wr_ptr wrapped, drain to rd_ptr=28 -> fetch_data spans indices 28..3 correctly across the wrap; ready=0 while used>16.
- used=20, enqueue 16 with concurrent accept 8 -> accepted, used'=28. Same enqueue without the accept -> dropped, used stays 20.
- Enqueue 5 bytes and assert limit_do -> fetch_limit=0; accept 5 -> next cycle used=0, fetch_limit=1; pr_reset -> fetch_limit=0.
- rst_n asserted mid-operation with used=12 and pf pending -> outputs go to reset values immediately, without waiting for clk. Enqueue and accept asserted together with pr_reset -> used=0 next cycle.
